regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined datapath.
- Successor of the fixed 32x32, 2-read/1-write register file.
- Adds configurable width, depth and port counts, optional hardwired-zero register 0, and write-to-read bypass.
- Adds a busy scoreboard that tracks registers with an in-flight writeback; the hazard/stall logic consumes it.

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of architectural registers, 2..64.
- ADDR_W, $clog2(NUM_REGS): address width (derived).
- NUM_RD, 2: number of asynchronous read ports, 1..4.
- NUM_WR, 1: number of synchronous write ports, 1..2.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- Clock, in, 1: clock, rising edge.
- nReset, in, 1: asynchronous active-low reset.
- RdAddr, in, NUM_RD x ADDR_W: read addresses.
- RdData, out, NUM_RD x DATA_W: read data.
- RdBusy, out, NUM_RD: addressed register has a pending write.
- WrEn, in, NUM_WR: write enables.
- WrAddr, in, NUM_WR x ADDR_W: write addresses.
- WrData, in, NUM_WR x DATA_W: write data.
- IssueEn, in, 1: mark the destination of an issuing instruction busy.
- IssueAddr, in, ADDR_W: destination register of that instruction.
- WrCollide, out, 1: registered flag; previous cycle had two enabled writes to the same address.
- BusyCount, out, $clog2(NUM_REGS)+1: registered count of busy registers.

Behaviour:
- Reset: interface is nReset, asynchronous, active-low; clock is Clock.
  - All registers go to 0, all busy bits to 0.
  - WrCollide = 0, BusyCount = 0.
  - RdData reads 0 and RdBusy reads 0 for every address.
  - Reset asserted mid-operation discards pending writes and issues in that cycle.
- Write:
  - On the rising edge, each port with WrEn=1 and an in-range address stores WrData; data is visible after the edge.
  - Addresses >= NUM_REGS are ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Same-address writes (NUM_WR=2, both enabled, same valid address):
  - Port 1 wins.
  - WrCollide = 1 in the following cycle, otherwise 0.
  - Writes to a discarded address (out of range, or 0 with ZERO_REG=1) never set WrCollide.
- Read:
  - Combinational, zero latency.
  - Out-of-range address returns 0.
  - With ZERO_REG=1, address 0 returns 0.
- Bypass (BYPASS=1): if a port has WrEn=1 with WrAddr equal to RdAddr and the write is not discarded:
  - RdData = that WrData; port 1 has priority when both ports hit.
  - RdBusy for that read port = 0.
  - With BYPASS=0, reads return the stored value until the edge.
- Scoreboard, one busy bit per register, updated on the rising edge:
  - IssueEn=1 sets busy[IssueAddr].
  - Any accepted write clears busy[WrAddr].
  - Issue and write to the same address in the same cycle: busy stays set; the newer producer wins.
  - Issue to address 0 (ZERO_REG=1) or to an out-of-range address: no effect.
  - A write to a non-busy register is legal and leaves it clear.
  - Without bypass, RdBusy[i] = busy[RdAddr[i]].
- BusyCount:
  - Population count of the busy vector after the update, registered, so it equals the bit count one cycle after the edge.
  - Never exceeds NUM_REGS-ZERO_REG.
- Assertions (simulation only):
  - With ZERO_REG=1, register 0 is 0 and not busy after reset.
  - BusyCount matches the popcount of the busy bits.

Decomposition:
- Package regfile_pkg:
  - DATA_W_DEF and NUM_REGS_DEF constants.
  - typedef reg_addr_t, logic [ADDR_W_DEF-1:0].
  - typedef reg_data_t, logic [DATA_W_DEF-1:0].
  - Function popcount used by BusyCount.
- Sub-module regfile_scoreboard:
  - Contains the busy vector, set/clear priority and BusyCount.
  - Instantiated once.
  - Storage, write ports and read/bypass muxing stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> RdData = 0, RdBusy = 0, BusyCount = 0, WrCollide = 0.
- Write 0xDEADBEEF to r5; next cycle read r5 -> 0xDEADBEEF. Write 0x1234 to r0, read r0 -> 0 (ZERO_REG=1).
- BYPASS=1: in one cycle WrEn, WrAddr=7, WrData=0xA5A5A5A5 with RdAddr[0]=7 -> RdData[0]=0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> old value 0.
- NUM_WR=2: both ports write r9, port0 0x1, port1 0x2 -> r9 = 0x2, WrCollide=1 for exactly one cycle.
- Issue r3 and r4 -> next cycle RdBusy on r3 = 1, BusyCount=2. Write r3 -> r3 busy clears, BusyCount=1. Issue and write r4 in the same cycle -> r4 stays busy.
- Issue r6 and write r2, then assert nReset mid-cycle -> all outputs return to 0 asynchronously; r2 reads 0 after reset release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, storage types and the population-count helper for the
// multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  // Widest busy vector the register file supports (NUM_REGS up to 64).
  localparam int POP_W        = 64;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register marking an in-flight writeback, plus
// a registered count of busy registers for the hazard logic.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = $clog2(NUM_REGS) + 1
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_WR-1:0]        wr_accept,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [NUM_REGS-1:0]      busy,
  output logic [CNT_W-1:0]         busy_count
);

  logic                issue_ok;
  logic [NUM_REGS-1:0] busy_next;

  assign issue_ok = issue_en
                    && ({1'b0, issue_addr} < (ADDR_W+1)'(NUM_REGS))
                    && !((ZERO_REG != 0) && (issue_addr == '0));

  // Clears first, then the issue: a same-cycle issue is the newer producer.
  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_accept[p]) begin
        busy_next[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (issue_ok) begin
      busy_next[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= CNT_W'(popcount(POP_W'(busy_next)));
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge Clock) disable iff (!nReset)
                   busy_count == CNT_W'(popcount(POP_W'(busy))));
  assert property (@(posedge Clock) disable iff (!nReset)
                   busy_count <= CNT_W'(NUM_REGS - ZERO_REG));
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with asynchronous reads, optional
// hardwired zero register, write-to-read bypass and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = $clog2(NUM_REGS) + 1
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic [NUM_WR-1:0]        WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] WrData,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueAddr,
  output logic                     WrCollide,
  output logic [CNT_W-1:0]         BusyCount
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [ADDR_W-1:0]   wr_addr [NUM_WR];
  logic [DATA_W-1:0]   wr_data [NUM_WR];
  logic [NUM_WR-1:0]   wr_accept;
  logic [NUM_REGS-1:0] busy;
  logic                collide_next;

  // An address names real storage: in range and not the hardwired zero.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    assign wr_addr[gi]   = WrAddr[gi*ADDR_W +: ADDR_W];
    assign wr_data[gi]   = WrData[gi*DATA_W +: DATA_W];
    assign wr_accept[gi] = WrEn[gi] && addr_live(wr_addr[gi]);
  end

  // Higher-numbered write ports are applied last so they win on a collision.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_accept[p]) begin
          regs[wr_addr[p]] <= wr_data[p];
        end
      end
    end
  end

  if (NUM_WR == 2) begin : g_collide
    assign collide_next = (&wr_accept) && (wr_addr[0] == wr_addr[1]);
  end else begin : g_no_collide
    assign collide_next = 1'b0;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      WrCollide <= 1'b0;
    end else begin
      WrCollide <= collide_next;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .Clock      (Clock),
    .nReset     (nReset),
    .issue_en   (IssueEn),
    .issue_addr (IssueAddr),
    .wr_accept  (wr_accept),
    .wr_addr    (WrAddr),
    .busy       (busy),
    .busy_count (BusyCount)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;

    assign rd_addr = RdAddr[gi*ADDR_W +: ADDR_W];

    // Reads are forced to zero while reset is held, bypass included.
    always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (nReset && addr_live(rd_addr)) begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
      end
      if ((BYPASS != 0) && nReset) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_accept[p] && (wr_addr[p] == rd_addr)) begin
            rd_data = wr_data[p];
            rd_busy = 1'b0;
          end
        end
      end
    end

    assign RdData[gi*DATA_W +: DATA_W] = rd_data;
    assign RdBusy[gi]                  = rd_busy;
  end

`ifndef SYNTHESIS
  if (ZERO_REG != 0) begin : g_zero_chk
    assert property (@(posedge Clock) disable iff (!nReset)
                     (regs[0] == '0) && !busy[0]);
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 2-write-port bypassing instance and a
// 1-write-port non-bypassing instance share stimulus.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam int K_RDATA    = 0;
  localparam int K_RBUSY    = 1;
  localparam int K_COUNT    = 2;
  localparam int K_COLL     = 3;
  localparam int K_NB_RDATA = 4;
  localparam int K_NB_RBUSY = 5;
  localparam int K_NB_COUNT = 6;
  localparam int K_NB_COLL  = 7;

  logic            Clock;
  logic            nReset;
  logic [2*AW-1:0] RdAddr;
  logic [2*DW-1:0] RdData;
  logic [1:0]      RdBusy;
  logic [1:0]      WrEn;
  logic [2*AW-1:0] WrAddr;
  logic [2*DW-1:0] WrData;
  logic            IssueEn;
  logic [AW-1:0]   IssueAddr;
  logic            WrCollide;
  logic [5:0]      BusyCount;
  logic [2*DW-1:0] nb_rd_data;
  logic [1:0]      nb_rd_busy;
  logic            nb_collide;
  logic [5:0]      nb_count;

  regfile_mp #(.NUM_WR(2), .BYPASS(1)) dut (
    .Clock(Clock), .nReset(nReset),
    .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr),
    .WrCollide(WrCollide), .BusyCount(BusyCount)
  );

  regfile_mp #(.NUM_WR(1), .BYPASS(0)) dut_nb (
    .Clock(Clock), .nReset(nReset),
    .RdAddr(RdAddr), .RdData(nb_rd_data), .RdBusy(nb_rd_busy),
    .WrEn(WrEn[0:0]), .WrAddr(WrAddr[AW-1:0]), .WrData(WrData[DW-1:0]),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr),
    .WrCollide(nb_collide), .BusyCount(nb_count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  // Reference model of the bypassing instance.
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_coll;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observed(int kind, int port);
    case (kind)
      K_RDATA:    return RdData[port*DW +: DW];
      K_RBUSY:    return {31'b0, RdBusy[port]};
      K_COUNT:    return {26'b0, BusyCount};
      K_COLL:     return {31'b0, WrCollide};
      K_NB_RDATA: return nb_rd_data[port*DW +: DW];
      K_NB_RBUSY: return {31'b0, nb_rd_busy[port]};
      K_NB_COUNT: return {26'b0, nb_count};
      K_NB_COLL:  return {31'b0, nb_collide};
      default:    return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(string tag, int kind, int port, logic [31:0] exp);
    sb.push_back('{tag, kind, port, exp});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, observed(e.kind, e.port), e.exp);
    end
  endtask

  function automatic logic [31:0] m_rd(logic [4:0] a);
    if (!nReset) return 32'h0;
    if (WrEn[1] && WrAddr[9:5] == a && a != 0) return WrData[63:32];
    if (WrEn[0] && WrAddr[4:0] == a && a != 0) return WrData[31:0];
    return (a == 0) ? 32'h0 : m_mem[a];
  endfunction

  function automatic logic m_rb(logic [4:0] a);
    if (!nReset || a == 0) return 1'b0;
    if (WrEn[1] && WrAddr[9:5] == a) return 1'b0;
    if (WrEn[0] && WrAddr[4:0] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic expect_model(string tag);
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = RdAddr[p*AW +: AW];
      expect_val({tag, "_data"}, K_RDATA, p, m_rd(a));
      expect_val({tag, "_busy"}, K_RBUSY, p, {31'b0, m_rb(a)});
    end
    expect_val({tag, "_count"}, K_COUNT, 0, $countones(m_busy));
    expect_val({tag, "_coll"}, K_COLL, 0, {31'b0, m_coll});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_busy = 32'h0;
    m_coll = 1'b0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic step();
    logic [4:0] a;
    @(posedge Clock);
    #1;
    if (nReset) begin
      m_coll = (WrEn == 2'b11) && (WrAddr[4:0] == WrAddr[9:5]) && (WrAddr[4:0] != 0);
      for (int p = 0; p < 2; p++) begin
        a = WrAddr[p*AW +: AW];
        if (WrEn[p] && a != 0) begin
          m_mem[a] = WrData[p*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (IssueEn && IssueAddr != 0) m_busy[IssueAddr] = 1'b1;
    end
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    WrEn[p] = 1'b1;
    WrAddr[p*AW +: AW] = a;
    WrData[p*DW +: DW] = d;
  endtask

  task automatic idle();
    WrEn    = 2'b00;
    IssueEn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nReset = 1'b0;
    RdAddr = '0; WrEn = '0; WrAddr = '0; WrData = '0;
    IssueEn = 1'b0; IssueAddr = '0;
    model_clear();
    repeat (2) @(posedge Clock);
    #1;
    nReset = 1'b1;

    // Reset state: every address reads 0 and not busy on both instances
    for (int a = 0; a < 32; a++) begin
      RdAddr = {5'(a), 5'(a)};
      @(negedge Clock);
      expect_val("rst_rd0", K_RDATA, 0, 0);
      expect_val("rst_rd1", K_RDATA, 1, 0);
      expect_val("rst_busy0", K_RBUSY, 0, 0);
      expect_val("rst_busy1", K_RBUSY, 1, 0);
      expect_val("rst_nb_rd0", K_NB_RDATA, 0, 0);
      drain();
    end
    expect_val("rst_count", K_COUNT, 0, 0);
    expect_val("rst_coll", K_COLL, 0, 0);
    expect_val("rst_nb_count", K_NB_COUNT, 0, 0);
    expect_val("rst_nb_coll", K_NB_COLL, 0, 0);
    drain();

    // Basic write/readback and zero register
    step();
    wr(0, 5'd5, 32'hDEADBEEF);
    RdAddr = {5'd0, 5'd5};
    step(); idle(); #1;
    expect_val("r5_readback", K_RDATA, 0, 32'hDEADBEEF);
    expect_model("after_r5");
    drain();
    wr(0, 5'd0, 32'h1234);
    RdAddr[4:0] = 5'd0;
    #1;
    expect_val("r0_no_bypass", K_RDATA, 0, 0);
    drain();
    step(); idle(); #1;
    expect_val("r0_readback", K_RDATA, 0, 0);
    expect_val("r0_nb_readback", K_NB_RDATA, 0, 0);
    drain();

    // Bypass versus no bypass, with r7 busy beforehand
    IssueEn = 1'b1; IssueAddr = 5'd7;
    step(); idle();
    wr(0, 5'd7, 32'hA5A5A5A5);
    RdAddr[4:0] = 5'd7;
    #1;
    expect_val("bypass_data", K_RDATA, 0, 32'hA5A5A5A5);
    expect_val("bypass_busy", K_RBUSY, 0, 0);
    expect_val("nobypass_old", K_NB_RDATA, 0, 0);
    expect_val("nobypass_busy", K_NB_RBUSY, 0, 1);
    drain();
    step(); idle(); #1;
    expect_val("nobypass_after", K_NB_RDATA, 0, 32'hA5A5A5A5);
    expect_val("nobypass_busy_clr", K_NB_RBUSY, 0, 0);
    expect_val("r7_busy_clr", K_RBUSY, 0, 0);
    drain();

    // Same-address writes: port 1 wins, collide flag for one cycle
    wr(0, 5'd9, 32'h1);
    wr(1, 5'd9, 32'h2);
    RdAddr[4:0] = 5'd9;
    #1;
    expect_val("bypass_port1_prio", K_RDATA, 0, 32'h2);
    expect_val("coll_before_edge", K_COLL, 0, 0);
    drain();
    step(); idle(); #1;
    expect_val("r9_port1_wins", K_RDATA, 0, 32'h2);
    expect_val("collide_set", K_COLL, 0, 1);
    drain();
    step(); #1;
    expect_val("collide_one_cycle", K_COLL, 0, 0);
    drain();
    wr(0, 5'd0, 32'hF0);
    wr(1, 5'd0, 32'hF1);
    step(); idle(); #1;
    expect_val("collide_r0_ignored", K_COLL, 0, 0);
    drain();
    wr(0, 5'd10, 32'h10);
    wr(1, 5'd11, 32'h11);
    step(); idle();
    RdAddr = {5'd11, 5'd10};
    #1;
    expect_val("dual_wr_r10", K_RDATA, 0, 32'h10);
    expect_val("dual_wr_r11", K_RDATA, 1, 32'h11);
    expect_model("dual_wr");
    drain();

    // Scoreboard
    IssueEn = 1'b1; IssueAddr = 5'd3;
    step(); #1;
    expect_val("count_after_r3", K_COUNT, 0, 1);
    drain();
    IssueAddr = 5'd4;
    step(); idle();
    RdAddr = {5'd4, 5'd3};
    #1;
    expect_val("busy_r3", K_RBUSY, 0, 1);
    expect_val("busy_r4", K_RBUSY, 1, 1);
    expect_val("count_two", K_COUNT, 0, 2);
    drain();
    wr(0, 5'd3, 32'h33);
    #1;
    expect_val("busy_r3_bypass", K_RBUSY, 0, 0);
    drain();
    step(); idle(); #1;
    expect_val("busy_r3_cleared", K_RBUSY, 0, 0);
    expect_val("count_after_wr_r3", K_COUNT, 0, 1);
    drain();
    IssueEn = 1'b1; IssueAddr = 5'd4;
    wr(0, 5'd4, 32'h44);
    step(); idle(); #1;
    expect_val("busy_r4_reissue", K_RBUSY, 1, 1);
    expect_val("count_reissue", K_COUNT, 0, 1);
    expect_val("r4_data", K_RDATA, 1, 32'h44);
    drain();
    IssueEn = 1'b1; IssueAddr = 5'd0;
    step(); idle();
    RdAddr[4:0] = 5'd0;
    #1;
    expect_val("issue_r0_busy", K_RBUSY, 0, 0);
    expect_val("issue_r0_count", K_COUNT, 0, 1);
    drain();
    wr(0, 5'd12, 32'h12);
    step(); idle(); #1;
    expect_val("write_nonbusy_count", K_COUNT, 0, 1);
    drain();
    for (int a = 0; a < 32; a++) begin
      RdAddr = {5'(a), 5'd0};
      @(negedge Clock);
      expect_model("sweep");
      drain();
    end

    // Asynchronous reset in mid-cycle discards pending write and issue
    step();
    IssueEn = 1'b1; IssueAddr = 5'd6;
    wr(0, 5'd2, 32'h22);
    RdAddr = {5'd4, 5'd2};
    #1;
    expect_val("pre_rst_bypass", K_RDATA, 0, 32'h22);
    expect_val("pre_rst_busy_r4", K_RBUSY, 1, 1);
    expect_val("pre_rst_count", K_COUNT, 0, 1);
    drain();
    #2;
    nReset = 1'b0;
    #1;
    model_clear();
    expect_val("rst_async_rd", K_RDATA, 0, 0);
    expect_val("rst_async_busy", K_RBUSY, 1, 0);
    expect_val("rst_async_count", K_COUNT, 0, 0);
    expect_val("rst_async_coll", K_COLL, 0, 0);
    expect_val("rst_async_nb_count", K_NB_COUNT, 0, 0);
    drain();
    @(posedge Clock);
    #1;
    idle();
    nReset = 1'b1;
    #1;
    expect_val("r2_after_reset", K_RDATA, 0, 0);
    expect_val("r4_busy_after_reset", K_RBUSY, 1, 0);
    drain();
    RdAddr = {5'd6, 5'd5};
    #1;
    expect_val("r5_after_reset", K_RDATA, 0, 0);
    expect_val("r6_busy_after_reset", K_RBUSY, 1, 0);
    expect_val("count_after_reset", K_COUNT, 0, 0);
    drain();
    wr(0, 5'd2, 32'h77);
    RdAddr = {5'd6, 5'd2};
    step(); idle(); #1;
    expect_model("post_reset_wr");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
